// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback path.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_fifo.sv
// In-order write queue with push/pop/flush; exports per-entry valid and contents for bypass search.
module regfile_wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  wb_entry_t             wr_entry,
  output wb_entry_t             head_entry,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output logic [PW-1:0]         head,
  output logic [DEPTH-1:0]      ent_vld,
  output wb_entry_t [DEPTH-1:0] ent
);
  wb_entry_t [DEPTH-1:0] r_mem;
  logic [DEPTH-1:0]      r_vld;
  logic [PW-1:0]         r_head, r_tail;
  logic [CW-1:0]         r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      // Flush overrides both a same-cycle push and the pop bookkeeping.
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_mem[r_tail] <= wr_entry;
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + PW'(1);
      end
      if (pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_entry = r_mem[r_head];
  assign full       = (r_count == CW'(DEPTH));
  assign empty      = (r_count == '0);
  assign count      = r_count;
  assign head       = r_head;
  assign ent_vld    = r_vld;
  assign ent        = r_mem;
endmodule

// File: rtl/regfile_writeback.sv
// Regfile write-side queue: r0 filter, one drain per cycle into we/wa/wd, optional bypass lookup.
// Define WB_BYPASS_EN to enable the lk_hit/lk_data search; otherwise those outputs are tied 0.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   flush,
  input  logic                   rf_busy,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_wa,
  output logic [DATA_W-1:0]      rf_wd,
  input  logic [ADDR_W-1:0]      lk_addr,
  output logic                   lk_hit,
  output logic [DATA_W-1:0]      lk_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic                  w_full, w_empty, w_push, w_pop;
  logic [PW-1:0]         w_head;
  logic [DEPTH-1:0]      w_vld;
  wb_entry_t             w_head_ent, w_wr_ent;
  wb_entry_t [DEPTH-1:0] w_ent;

  // Ready depends only on occupancy, never on this cycle's pop.
  assign in_ready = ~w_full;
  assign w_push   = in_valid & in_ready & (in_addr != '0) & ~flush;
  assign w_pop    = ~w_empty & ~rf_busy;
  assign w_wr_ent = '{addr: in_addr, data: in_data};

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_push),
    .pop        (w_pop),
    .flush      (flush),
    .wr_entry   (w_wr_ent),
    .head_entry (w_head_ent),
    .full       (w_full),
    .empty      (w_empty),
    .count      (count),
    .head       (w_head),
    .ent_vld    (w_vld),
    .ent        (w_ent)
  );

  assign rf_we = w_pop;
  assign rf_wa = w_empty ? '0 : w_head_ent.addr;
  assign rf_wd = w_empty ? '0 : w_head_ent.data;

`ifdef WB_BYPASS_EN
  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (lk_addr != '0 && w_vld[w_head + PW'(k)] && w_ent[w_head + PW'(k)].addr == lk_addr) begin
        lk_hit  = 1'b1;
        lk_data = w_ent[w_head + PW'(k)].data;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{lk_addr, w_vld, w_ent, w_head};
  assign lk_hit   = 1'b0;
  assign lk_data  = '0;
`endif
endmodule
